// File: rtl/uart_pkg.sv
// Shared state encoding, line levels and parity helper for the UART transmit scheduler.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam logic START_LVL  = 1'b0;
  localparam logic STOP_LVL   = 1'b1;
  localparam logic IDLE_LVL   = 1'b1;

  localparam int   DEF_DATA_W = 8;
  localparam int   MAX_DATA_W = 64;

  // Even parity: XOR of all bits, so data plus parity holds an even number of ones.
  function automatic logic even_parity(input logic [MAX_DATA_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr+1 (mod N_REQ).
module uart_rr_arbiter
  import uart_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] pick,
  output logic [IW-1:0]    pick_idx,
  output logic             any_req
);

  logic          found_s;
  logic [IW-1:0] cand_s;

  // Walk the ring once starting just after the last winner.
  always_comb begin
    pick     = {N_REQ{1'b0}};
    pick_idx = {IW{1'b0}};
    any_req  = |req;
    found_s  = 1'b0;
    cand_s   = {IW{1'b0}};
    for (int k = 1; k <= N_REQ; k++) begin
      cand_s = IW'((int'(ptr) + k) % N_REQ);
      if (!found_s && req[cand_s]) begin
        found_s        = 1'b1;
        pick[cand_s]   = 1'b1;
        pick_idx       = cand_s;
      end else begin
        found_s        = found_s;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// UART transmit scheduler: round-robin byte arbitration feeding one serializer.
// Optional even parity bit after the data bits when UART_TX_PARITY_EN is defined.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter  int N_REQ  = 4,
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int DIV_W  = 16,
  localparam int IW     = $clog2(N_REQ),
  localparam int BW     = $clog2(DATA_W + 1)
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   din,
  input  logic [DIV_W-1:0]          baud_div,
  output logic [N_REQ-1:0]          grant,
  output logic [IW-1:0]             owner,
  output logic                      busy,
  output logic                      tx
);

  tx_state_t          state_r;
  logic [IW-1:0]      ptr_r;
  logic [BW-1:0]      bit_cnt_r;
  logic [DIV_W-1:0]   baud_cnt_r;
  logic [DIV_W-1:0]   div_r;
  logic [DATA_W-1:0]  shift_r;
`ifdef UART_TX_PARITY_EN
  logic               par_r;
`endif

  logic [N_REQ-1:0]   pick_s;
  logic [IW-1:0]      pick_idx_s;
  logic               any_req_s;
  logic [DATA_W-1:0]  pick_byte_s;
  logic               bit_done_s;
  logic               last_bit_s;

  uart_rr_arbiter #(
    .N_REQ    (N_REQ)
  ) u_arb (
    .req      (req),
    .ptr      (ptr_r),
    .pick     (pick_s),
    .pick_idx (pick_idx_s),
    .any_req  (any_req_s)
  );

  assign pick_byte_s = din[int'(pick_idx_s)*DATA_W +: DATA_W];
  assign bit_done_s  = (baud_cnt_r == {DIV_W{1'b0}});
  assign last_bit_s  = (bit_cnt_r == BW'(DATA_W - 1));

  // Frame sequencer; every output is registered and the divisor is frozen per frame.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_r    <= IDLE;
      tx         <= IDLE_LVL;
      busy       <= 1'b0;
      grant      <= {N_REQ{1'b0}};
      owner      <= {IW{1'b0}};
      ptr_r      <= IW'(N_REQ - 1);
      bit_cnt_r  <= {BW{1'b0}};
      baud_cnt_r <= {DIV_W{1'b0}};
      div_r      <= {DIV_W{1'b0}};
      shift_r    <= {DATA_W{1'b0}};
`ifdef UART_TX_PARITY_EN
      par_r      <= 1'b0;
`endif
    end else begin
      grant <= {N_REQ{1'b0}};
      case (state_r)
        IDLE: begin
          if (any_req_s) begin
            shift_r    <= pick_byte_s;
            div_r      <= baud_div;
            baud_cnt_r <= baud_div;
            bit_cnt_r  <= {BW{1'b0}};
            grant      <= pick_s;
            owner      <= pick_idx_s;
            ptr_r      <= pick_idx_s;
            busy       <= 1'b1;
            tx         <= START_LVL;
`ifdef UART_TX_PARITY_EN
            par_r      <= even_parity(MAX_DATA_W'(pick_byte_s));
`endif
            state_r    <= START;
          end else begin
            busy       <= 1'b0;
            tx         <= IDLE_LVL;
          end
        end
        START: begin
          if (bit_done_s) begin
            baud_cnt_r <= div_r;
            bit_cnt_r  <= {BW{1'b0}};
            tx         <= shift_r[0];
            shift_r    <= shift_r >> 1;
            state_r    <= DATA;
          end else begin
            baud_cnt_r <= baud_cnt_r - DIV_W'(1);
          end
        end
        DATA: begin
          if (bit_done_s && last_bit_s) begin
            baud_cnt_r <= div_r;
`ifdef UART_TX_PARITY_EN
            tx         <= par_r;
            state_r    <= PARITY;
`else
            tx         <= STOP_LVL;
            state_r    <= STOP;
`endif
          end else if (bit_done_s) begin
            baud_cnt_r <= div_r;
            bit_cnt_r  <= bit_cnt_r + BW'(1);
            tx         <= shift_r[0];
            shift_r    <= shift_r >> 1;
          end else begin
            baud_cnt_r <= baud_cnt_r - DIV_W'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_done_s) begin
            baud_cnt_r <= div_r;
            tx         <= STOP_LVL;
            state_r    <= STOP;
          end else begin
            baud_cnt_r <= baud_cnt_r - DIV_W'(1);
          end
        end
`endif
        STOP: begin
          if (bit_done_s) begin
            busy       <= 1'b0;
            tx         <= IDLE_LVL;
            state_r    <= IDLE;
          end else begin
            baud_cnt_r <= baud_cnt_r - DIV_W'(1);
          end
        end
        default: begin
          busy    <= 1'b0;
          tx      <= IDLE_LVL;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
